sync_autocorr_det: RTL and testbench
====================================

# sync_autocorr_det

Parametrised delay-and-correlate preamble detector for the receive front end. Successor to the fixed 16-sample short-preamble detector; it feeds the same downstream long-sync and demod control. Adds generic IQ width, correlation lag and window length, a programmable threshold ratio, and a post-detection hold-off state. Computes a windowed autocorrelation at lag `DELAY` and a windowed power. It declares a preamble once the correlation magnitude stays above a fraction of the power for `min_plateau` strobes.

## Interface
- `IQ_WIDTH`, 16: bits per I and per Q component (signed).
- `DELAY`, 16: correlation lag in samples, 1..64.
- `LOG2_WIN`, 4: log2 of the averaging window length.
- `CNT_WIDTH`, 16: width of the plateau and hold-off counters.
- `clock`, in, 1: sole clock.
- `reset`, in, 1: asynchronous, active-high; clears all state.
- `enable`, in, 1: when low, all state freezes and `preamble_detected` is 0.
- `sample_in`, in, 2*IQ_WIDTH: {I, Q}, each two's complement.
- `sample_in_strobe`, in, 1: sample valid. The block advances only on strobes.
- `min_plateau`, in, CNT_WIDTH: required number of consecutive above-threshold strobes.
- `thres_num`, in, 4: threshold ratio in eighths (6 means 0.75).
- `holdoff`, in, CNT_WIDTH: number of strobes to ignore after a detection.
- `preamble_detected`, out, 1: one-cycle pulse. Reset value 0.
- `corr_i`, `corr_q`, out, ACC_W = 2*IQ_WIDTH+1+LOG2_WIN: correlation sums latched at detection. Reset value 0.
- `det_state`, out, 2: FSM state. Reset value FILL.

## Operation
- Product and power per strobe:
  - p = x[n]·conj(x[n−DELAY]), with each component 2*IQ_WIDTH+1 bits signed.
  - r = I²+Q², 2*IQ_WIDTH bits unsigned.
- Window sums:
  - P = running sum of the last 2^LOG2_WIN products (ACC_W bits signed).
  - R = running sum of the last 2^LOG2_WIN powers (2*IQ_WIDTH+LOG2_WIN bits unsigned).
  - Each sum is updated as acc + new − oldest, using an internal product/power history of depth 2^LOG2_WIN.
- Magnitude: m = max(|P_i|,|P_q|) + (min(|P_i|,|P_q|) >> 1). |most-negative| saturates to the most-positive value.
- Above-threshold condition: above = (m·8 > thres_num·R). The comparison is evaluated at full width with no truncation.
- FSM states:
  - FILL (0): count strobes up to DELAY + 2^LOG2_WIN, then go to SEARCH. No decisions are made in this state.
  - SEARCH (1): when above=1, load plateau_cnt=1, clear the sign counters, then count the sign (see PLATEAU) and go to PLATEAU.
  - PLATEAU (2): on each strobe:
    - If above=0, go to SEARCH with counters cleared.
    - Otherwise, increment plateau_cnt (saturating).
    - Increment pos_cnt if the current I ≥ 0, else neg_cnt.
    - When plateau_cnt == min_plateau and the qualify condition holds: pulse `preamble_detected`, latch P into `corr_i`/`corr_q`, load hold_cnt = holdoff, and go to HOLDOFF.
    - If plateau_cnt == min_plateau but the qualify condition fails, stay in PLATEAU.
  - HOLDOFF (3): decrement hold_cnt on each strobe. At 0, go to SEARCH. holdoff = 0 means return to SEARCH on the next strobe.
- min_plateau = 0 is treated as 1.
- Sums and delay lines keep updating in every state, including HOLDOFF.
- If `enable` drops mid-operation, state holds and resumes exactly where it stopped.
- An asynchronous `reset` mid-operation returns the block to FILL with all histories cleared to zero.

## Timing
- For a strobe accepted at cycle t:
  - the products and powers are registered at t+1;
  - the sums at t+2;
  - m and `above` at t+3;
  - the FSM update and `preamble_detected`/`corr_*` at t+4.
- Total latency is 4 cycles. The pipeline stage valids are strobe-tagged, so gaps between strobes are allowed.
- Back-to-back strobes on every cycle are supported at full throughput.
- `preamble_detected` is high for exactly one clock per detection.

## Configuration
- `SYNC_AUTOCORR_DET_SIGN_CHECK_EN`:
  - Defined: qualify requires pos_cnt > (min_plateau>>2) and neg_cnt > (min_plateau>>2). This rejects DC or constant-power input.
  - Undefined: qualify is always true, so detection is on plateau length alone. The sign counters are not built.

## Test plan
- Periodic 16-sample sequence (I/Q amplitude ±4000), thres_num=6, min_plateau=100, holdoff=200 → a single `preamble_detected` pulse exactly 100 strobes after the first above-threshold strobe, plus the 4-cycle latency. No second pulse until 200 strobes later.
- Constant DC input I=8000, Q=0 → with SIGN_CHECK_EN: no detection. Without it: a detection after min_plateau strobes.
- White noise (LFSR, ±2000) for 10000 strobes → `preamble_detected` never asserts. `det_state` oscillates only between SEARCH and PLATEAU.
- Preamble cut off after 50 strobes, with min_plateau=100 → no pulse, and the FSM returns to SEARCH on the first below-threshold strobe.
- Assert `reset` asynchronously in PLATEAU, then release → outputs read 0 immediately, and no decision occurs before DELAY + 2^LOG2_WIN strobes.
- Parameter sweep IQ_WIDTH=12, DELAY=32, LOG2_WIN=5 with random strobe gaps → `corr_i`/`corr_q` match a bit-exact reference model at each pulse.

Source files
------------

// File: rtl/sync_autocorr_det.sv
// sync_autocorr_det: windowed delay-and-correlate preamble detector with a 4-cycle strobe pipeline.
// Build option: define SYNC_AUTOCORR_DET_SIGN_CHECK_EN to also require balanced I signs on the plateau.
module sync_autocorr_det #(
  parameter  int IQ_WIDTH  = 16,
  parameter  int DELAY     = 16,
  parameter  int LOG2_WIN  = 4,
  parameter  int CNT_WIDTH = 16,
  localparam int ACC_W     = 2*IQ_WIDTH+1+LOG2_WIN
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [2*IQ_WIDTH-1:0]   sample_in,
  input  logic                    sample_in_strobe,
  input  logic [CNT_WIDTH-1:0]    min_plateau,
  input  logic [3:0]              thres_num,
  input  logic [CNT_WIDTH-1:0]    holdoff,
  output logic                    preamble_detected,
  output logic signed [ACC_W-1:0] corr_i,
  output logic signed [ACC_W-1:0] corr_q,
  output logic [1:0]              det_state
);
  localparam int WIN    = 1 << LOG2_WIN;
  localparam int PW     = 2*IQ_WIDTH+1;
  localparam int RW     = 2*IQ_WIDTH;
  localparam int SW     = 2*IQ_WIDTH+LOG2_WIN;
  localparam int CW     = ACC_W+3;
  localparam int FILL_N = DELAY+WIN;
  localparam int FW     = $clog2(FILL_N+1);
  localparam int DPW    = (DELAY > 1) ? $clog2(DELAY) : 1;

  typedef enum logic [1:0] {FILL = 2'd0, SEARCH = 2'd1, PLATEAU = 2'd2, HOLDOFF = 2'd3} state_t;

  logic signed [IQ_WIDTH-1:0] in_i, in_q, old_i, old_q;
  logic [2*IQ_WIDTH-1:0]      dline_q [DELAY];
  logic [DPW-1:0]             dptr_q;
  logic signed [PW-1:0]       ei, eq, eoi, eoq, prod_i_d, prod_q_d, prod_i_q, prod_q_q;
  logic [RW-1:0]              pwr_d, pwr_q;
  logic                       v1_q, v2_q, v3_q;

  assign in_i  = sample_in[2*IQ_WIDTH-1:IQ_WIDTH];
  assign in_q  = sample_in[IQ_WIDTH-1:0];
  assign old_i = dline_q[dptr_q][2*IQ_WIDTH-1:IQ_WIDTH];
  assign old_q = dline_q[dptr_q][IQ_WIDTH-1:0];

  // x[n]*conj(x[n-DELAY]); operands widened first so products are exact
  always_comb begin
    ei       = PW'(in_i);
    eq       = PW'(in_q);
    eoi      = PW'(old_i);
    eoq      = PW'(old_q);
    prod_i_d = ei*eoi + eq*eoq;
    prod_q_d = eq*eoi - ei*eoq;
    pwr_d    = RW'(ei*ei + eq*eq);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < DELAY; k++) dline_q[k] <= '0;
      dptr_q   <= '0;
      v1_q     <= 1'b0;
      prod_i_q <= '0;
      prod_q_q <= '0;
      pwr_q    <= '0;
    end else if (enable) begin
      v1_q <= sample_in_strobe;
      if (sample_in_strobe) begin
        dline_q[dptr_q] <= sample_in;
        dptr_q          <= (dptr_q == DPW'(DELAY-1)) ? '0 : dptr_q + 1'b1;
        prod_i_q        <= prod_i_d;
        prod_q_q        <= prod_q_d;
        pwr_q           <= pwr_d;
      end
    end
  end

  logic signed [PW-1:0]    hist_i_q [WIN];
  logic signed [PW-1:0]    hist_q_q [WIN];
  logic [RW-1:0]           hist_r_q [WIN];
  logic [LOG2_WIN-1:0]     hptr_q;
  logic signed [ACC_W-1:0] acc_i_q, acc_q_q;
  logic [SW-1:0]           acc_r_q;

  // Running window sums: add newest, drop the entry it overwrites in the circular history
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < WIN; k++) begin
        hist_i_q[k] <= '0;
        hist_q_q[k] <= '0;
        hist_r_q[k] <= '0;
      end
      hptr_q  <= '0;
      v2_q    <= 1'b0;
      acc_i_q <= '0;
      acc_q_q <= '0;
      acc_r_q <= '0;
    end else if (enable) begin
      v2_q <= v1_q;
      if (v1_q) begin
        acc_i_q          <= acc_i_q + ACC_W'(prod_i_q) - ACC_W'(hist_i_q[hptr_q]);
        acc_q_q          <= acc_q_q + ACC_W'(prod_q_q) - ACC_W'(hist_q_q[hptr_q]);
        acc_r_q          <= acc_r_q + SW'(pwr_q) - SW'(hist_r_q[hptr_q]);
        hist_i_q[hptr_q] <= prod_i_q;
        hist_q_q[hptr_q] <= prod_q_q;
        hist_r_q[hptr_q] <= pwr_q;
        hptr_q           <= hptr_q + 1'b1;
      end
    end
  end

  function automatic logic [ACC_W-1:0] sat_abs(input logic signed [ACC_W-1:0] v);
    logic [ACC_W-1:0] r;
    if (v == {1'b1, {(ACC_W-1){1'b0}}}) r = {1'b0, {(ACC_W-1){1'b1}}};
    else if (v[ACC_W-1])                r = $unsigned(-v);
    else                                r = $unsigned(v);
    return r;
  endfunction

  logic [ACC_W-1:0]        abs_i, abs_q, mag_d;
  logic                    above_d, above_q;
  logic signed [ACC_W-1:0] p3_i_q, p3_q_q;

  always_comb begin
    abs_i = sat_abs(acc_i_q);
    abs_q = sat_abs(acc_q_q);
    if (abs_i >= abs_q) mag_d = abs_i + (abs_q >> 1);
    else                mag_d = abs_q + (abs_i >> 1);
    above_d = {mag_d, 3'b000} > (CW'(thres_num) * CW'(acc_r_q));
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      v3_q    <= 1'b0;
      above_q <= 1'b0;
      p3_i_q  <= '0;
      p3_q_q  <= '0;
    end else if (enable) begin
      v3_q <= v2_q;
      if (v2_q) begin
        above_q <= above_d;
        p3_i_q  <= acc_i_q;
        p3_q_q  <= acc_q_q;
      end
    end
  end

  state_t                  state_q, state_d;
  logic [CNT_WIDTH-1:0]    plat_q, plat_d, hold_q, hold_d, min_eff;
  logic [FW-1:0]           fill_q, fill_d;
  logic signed [ACC_W-1:0] corr_i_q, corr_i_d, corr_q_q, corr_q_d;
  logic                    det_q, det_d, qualify;

`ifdef SYNC_AUTOCORR_DET_SIGN_CHECK_EN
  logic                 neg1_q, neg2_q, neg3_q, sgn_load, sgn_clr, sgn_inc;
  logic [CNT_WIDTH-1:0] pos_q, neg_q;

  assign sgn_load = v3_q && (state_q == SEARCH) && above_q;
  assign sgn_clr  = v3_q && (state_q == PLATEAU) && !above_q;
  assign sgn_inc  = v3_q && (state_q == PLATEAU) && above_q;
  assign qualify  = (pos_q > (min_plateau >> 2)) && (neg_q > (min_plateau >> 2));

  // I sign travels with its strobe so it is counted against the matching decision
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      {neg1_q, neg2_q, neg3_q} <= 3'b000;
      pos_q <= '0;
      neg_q <= '0;
    end else if (enable) begin
      if (sample_in_strobe) neg1_q <= in_i[IQ_WIDTH-1];
      if (v1_q) neg2_q <= neg1_q;
      if (v2_q) neg3_q <= neg2_q;
      if (sgn_load) begin
        pos_q <= CNT_WIDTH'(!neg3_q);
        neg_q <= CNT_WIDTH'(neg3_q);
      end else if (sgn_clr) begin
        pos_q <= '0;
        neg_q <= '0;
      end else if (sgn_inc) begin
        if (neg3_q && neg_q != '1) neg_q <= neg_q + 1'b1;
        if (!neg3_q && pos_q != '1) pos_q <= pos_q + 1'b1;
      end
    end
  end
`else
  assign qualify = 1'b1;
`endif

  assign min_eff = (min_plateau == '0) ? CNT_WIDTH'(1) : min_plateau;

  always_comb begin
    state_d  = state_q;
    plat_d   = plat_q;
    hold_d   = hold_q;
    fill_d   = fill_q;
    corr_i_d = corr_i_q;
    corr_q_d = corr_q_q;
    det_d    = 1'b0;
    if (v3_q) begin
      case (state_q)
        FILL: begin
          if (fill_q == FW'(FILL_N-1)) state_d = SEARCH;
          else                         fill_d  = fill_q + 1'b1;
        end
        SEARCH: begin
          if (above_q) begin
            plat_d  = CNT_WIDTH'(1);
            state_d = PLATEAU;
          end
        end
        PLATEAU: begin
          if (!above_q) begin
            plat_d  = '0;
            state_d = SEARCH;
          end else begin
            if (plat_q != '1) plat_d = plat_q + 1'b1;
            if (plat_q == min_eff && qualify) begin
              det_d    = 1'b1;
              corr_i_d = p3_i_q;
              corr_q_d = p3_q_q;
              hold_d   = holdoff;
              state_d  = HOLDOFF;
            end
          end
        end
        HOLDOFF: begin
          if (hold_q <= CNT_WIDTH'(1)) state_d = SEARCH;
          else                         hold_d  = hold_q - 1'b1;
        end
        default: state_d = FILL;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= FILL;
      plat_q   <= '0;
      hold_q   <= '0;
      fill_q   <= '0;
      corr_i_q <= '0;
      corr_q_q <= '0;
      det_q    <= 1'b0;
    end else if (enable) begin
      state_q  <= state_d;
      plat_q   <= plat_d;
      hold_q   <= hold_d;
      fill_q   <= fill_d;
      corr_i_q <= corr_i_d;
      corr_q_q <= corr_q_d;
      det_q    <= det_d;
    end else begin
      det_q <= 1'b0;
    end
  end

  // Gated so a pulse never straddles an enable drop
  assign preamble_detected = det_q & enable;
  assign corr_i            = corr_i_q;
  assign corr_q            = corr_q_q;
  assign det_state         = state_q;

endmodule

// File: tb/tb_sync_autocorr_det.sv
// Bench for sync_autocorr_det: directed segments with random data, checked every cycle against a
// direct window-summation model and a rule-level detector model.
`timescale 1ns/1ps
module tb_sync_autocorr_det;
  localparam int IQW  = 16;
  localparam int DLY  = 16;
  localparam int L2W  = 4;
  localparam int CNTW = 16;
  localparam int WIN  = 1 << L2W;
  localparam int ACCW = 2*IQW+1+L2W;

  logic            clock = 1'b0;
  logic            reset, enable, sample_in_strobe;
  logic [2*IQW-1:0] sample_in;
  logic [CNTW-1:0] min_plateau, holdoff;
  logic [3:0]      thres_num;
  logic            preamble_detected;
  logic [ACCW-1:0] corr_i, corr_q;
  logic [1:0]      det_state;

  always #5 clock = ~clock;

  sync_autocorr_det #(.IQ_WIDTH(IQW), .DELAY(DLY), .LOG2_WIN(L2W), .CNT_WIDTH(CNTW)) dut (
    .clock(clock), .reset(reset), .enable(enable), .sample_in(sample_in),
    .sample_in_strobe(sample_in_strobe), .min_plateau(min_plateau), .thres_num(thres_num),
    .holdoff(holdoff), .preamble_detected(preamble_detected), .corr_i(corr_i),
    .corr_q(corr_q), .det_state(det_state)
  );

  typedef struct {
    bit              det;
    int              state;
    logic [ACCW-1:0] ci;
    logic [ACCW-1:0] cq;
  } rec_t;

  int checks = 0;
  int errors = 0;
  int xi[$];
  int xq[$];
  int m_state, m_fill, m_plat, m_hold, m_pos, m_neg, strobe_no;
  logic [ACCW-1:0] m_corr_i, m_corr_q;
  rec_t pipe[$];
  int last_state, dut_pulses, exp_pulses;
  int pat_i[16];
  int pat_q[16];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    rec_t r;
    xi.delete(); xq.delete();
    m_state = 0; m_fill = 0; m_plat = 0; m_hold = 0; m_pos = 0; m_neg = 0; strobe_no = 0;
    m_corr_i = '0; m_corr_q = '0; last_state = 0;
    pipe.delete();
    r.det = 0; r.state = 0; r.ci = '0; r.cq = '0;
    repeat (3) pipe.push_back(r);
  endtask

  // Window sums computed directly over the stored sample history (zeros before the first sample)
  task automatic model_strobe(input int si, input int sq, output bit det);
    longint pi, pq, r, ai, aq, bi, bq, abs_i, abs_q, mag;
    int n, minp;
    bit above, qual;
    pi = 0; pq = 0; r = 0; det = 0;
    xi.push_back(si); xq.push_back(sq);
    n = xi.size() - 1;
    strobe_no++;
    for (int k = n - WIN + 1; k <= n; k++) begin
      if (k >= 0) begin
        ai = xi[k]; aq = xq[k]; bi = 0; bq = 0;
        if (k >= DLY) begin bi = xi[k-DLY]; bq = xq[k-DLY]; end
        pi += ai*bi + aq*bq;
        pq += aq*bi - ai*bq;
        r  += ai*ai + aq*aq;
      end
    end
    abs_i = (pi < 0) ? -pi : pi;
    abs_q = (pq < 0) ? -pq : pq;
    mag   = (abs_i >= abs_q) ? abs_i + abs_q/2 : abs_q + abs_i/2;
    above = (mag*8 > longint'(thres_num)*r);
    minp  = (min_plateau == 0) ? 1 : int'(min_plateau);
`ifdef SYNC_AUTOCORR_DET_SIGN_CHECK_EN
    qual = (m_pos > int'(min_plateau >> 2)) && (m_neg > int'(min_plateau >> 2));
`else
    qual = 1'b1;
`endif
    case (m_state)
      0: begin
        m_fill++;
        if (m_fill == DLY + WIN) m_state = 1;
      end
      1: if (above) begin
        m_plat = 1; m_pos = (si >= 0); m_neg = (si < 0); m_state = 2;
      end
      2: if (!above) begin
        m_plat = 0; m_pos = 0; m_neg = 0; m_state = 1;
      end else begin
        if (m_plat == minp && qual) begin
          det = 1; m_corr_i = ACCW'(pi); m_corr_q = ACCW'(pq);
          m_hold = int'(holdoff); m_state = 3;
        end
        if (m_plat < 65535) m_plat++;
        if (si >= 0) m_pos++; else m_neg++;
      end
      default: if (m_hold <= 1) m_state = 1; else m_hold--;
    endcase
    if (det) $display("detection expected at strobe %0d corr=(%0d,%0d)", strobe_no, pi, pq);
  endtask

  task automatic step(input bit stb, input int si, input int sq, input bit en);
    rec_t rec;
    bit d;
    @(negedge clock);
    enable = en; sample_in_strobe = stb; sample_in = {IQW'(si), IQW'(sq)};
    if (en) begin
      d = 0;
      if (stb) model_strobe(si, sq, d);
      rec.det = d; rec.state = m_state; rec.ci = m_corr_i; rec.cq = m_corr_q;
      pipe.push_back(rec);
    end
    @(posedge clock); #1;
    if (preamble_detected) dut_pulses++;
    if (en) begin
      rec = pipe.pop_front();
      last_state = rec.state;
      if (rec.det) exp_pulses++;
      check("det", preamble_detected, rec.det);
      check("state", det_state, rec.state);
      check("corr_i", corr_i, rec.ci);
      check("corr_q", corr_q, rec.cq);
    end else begin
      check("det_when_disabled", preamble_detected, 0);
      check("state_frozen", det_state, last_state);
    end
  endtask

  task automatic do_reset_async();
    @(negedge clock);
    enable = 0; sample_in_strobe = 0;
    #2 reset = 1;
    #1;
    check("rst_det", preamble_detected, 0);
    check("rst_state", det_state, 0);
    check("rst_corr_i", corr_i, 0);
    check("rst_corr_q", corr_q, 0);
    model_reset();
    @(negedge clock);
    reset = 0;
  endtask

  function automatic int noise(input int amp);
    return int'($urandom_range(2*amp)) - amp;
  endfunction

  task automatic flush();
    repeat (4) step(0, 0, 0, 1);
  endtask

  task automatic seg_check(input string tag);
    check(tag, dut_pulses, exp_pulses);
    dut_pulses = 0; exp_pulses = 0;
  endtask

  initial begin
    reset = 1; enable = 0; sample_in_strobe = 0; sample_in = '0;
    min_plateau = 100; thres_num = 6; holdoff = 200;
    dut_pulses = 0; exp_pulses = 0;
    for (int k = 0; k < 16; k++) begin
      pat_i[k] = $urandom_range(1) ? 4000 : -4000;
      pat_q[k] = $urandom_range(1) ? 4000 : -4000;
    end
    do_reset_async();

    // Noise lead-in, then a long periodic preamble at full throughput
    for (int n = 0; n < 40; n++) step(1, noise(2000), noise(2000), 1);
    for (int n = 0; n < 700; n++) step(1, pat_i[n%16], pat_q[n%16], 1);
    flush();
    seg_check("pulses_periodic");

    // White noise with random strobe gaps
    for (int n = 0; n < 3000; n++) step($urandom_range(3) != 0, noise(2000), noise(2000), 1);
    flush();
    seg_check("pulses_noise");

    // Preamble cut off before the plateau completes
    for (int n = 0; n < 50; n++) step(1, pat_i[n%16], pat_q[n%16], 1);
    for (int n = 0; n < 200; n++) step(1, noise(2000), noise(2000), 1);
    flush();
    seg_check("pulses_cut");

    // Enable dropped mid-plateau with ignored strobes, then resumed
    for (int n = 0; n < 60; n++) step(1, pat_i[n%16], pat_q[n%16], 1);
    for (int n = 0; n < 6; n++) step(1, noise(3000), noise(3000), 0);
    for (int n = 60; n < 260; n++) step(1, pat_i[n%16], pat_q[n%16], 1);
    flush();
    seg_check("pulses_enable");

    // Constant DC input
    for (int n = 0; n < 300; n++) step(1, 8000, 0, 1);
    flush();
    seg_check("pulses_dc");

    // Asynchronous reset mid-plateau, then min_plateau 0 and holdoff 0 with random gaps
    for (int n = 0; n < 80; n++) step(1, pat_i[n%16], pat_q[n%16], 1);
    do_reset_async();
    min_plateau = 0; holdoff = 0;
    for (int n = 0; n < 400; n++) step($urandom_range(2) != 0, pat_i[n%16], pat_q[n%16], 1);
    flush();
    seg_check("pulses_after_reset");

    // Random threshold and short plateau over a mixed noisy preamble
    thres_num = 4'($urandom_range(2, 7)); min_plateau = 20; holdoff = 30;
    for (int n = 0; n < 600; n++)
      step($urandom_range(3) != 0, pat_i[n%16] + noise(1500), pat_q[n%16] + noise(1500), 1);
    flush();
    seg_check("pulses_mixed");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
